// File: rtl/result_wb_ctrl.sv
// Result write-back controller: RR-arbitrated threshold writes, then ordered drain.
// Define RESULT_DUP_CHECK_EN to drop and flag packets to already-written entries.
module result_wb_ctrl #(
  parameter int NUM_REQ    = 4,
  parameter int WIDTH_PKT  = 32,
  parameter int WIDTH_DATA = 13,
  parameter int DEPTH_R    = 21,
  parameter int WIDTH_ADDR = 9,
  parameter int THRE       = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*WIDTH_PKT-1:0]  req_pkt,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          mem_we,
  output logic [WIDTH_ADDR-1:0]         mem_addr,
  output logic [WIDTH_DATA:0]           mem_wdata,
  output logic                          mem_re,
  input  logic [WIDTH_DATA:0]           mem_rdata,
  output logic                          out_valid,
  output logic [WIDTH_DATA:0]           out_data,
  input  logic                          out_ready,
  output logic                          busy,
  output logic                          done,
  output logic                          err
);

  localparam int NUM_ENT = DEPTH_R * DEPTH_R;
  localparam int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW      = WIDTH_ADDR + 1;

  localparam logic [CW-1:0] ENT_LIM  = CW'(NUM_ENT);
  localparam logic [CW-1:0] LAST_CNT = CW'(NUM_ENT - 1);
  localparam logic [WIDTH_ADDR-1:0] LAST_ADDR = WIDTH_ADDR'(NUM_ENT - 1);
  localparam logic [WIDTH_DATA-1:0] THR = WIDTH_DATA'(THRE);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_COLLECT   = 3'd1;
  localparam logic [2:0] S_DRAIN_RD  = 3'd2;
  localparam logic [2:0] S_DRAIN_OUT = 3'd3;
  localparam logic [2:0] S_DONE      = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [WIDTH_ADDR-1:0] rd_addr_q, rd_addr_d;
  logic [PW-1:0]         rr_ptr_q, rr_ptr_d;
  logic                  wr_pend_q, wr_pend_d;
  logic [WIDTH_ADDR-1:0] wr_addr_q, wr_addr_d;
  logic [WIDTH_DATA:0]   wr_data_q, wr_data_d;
  logic                  cap_q, cap_d;
  logic [WIDTH_DATA:0]   out_data_q, out_data_d;
  logic                  err_q, err_d;

  logic [NUM_REQ-1:0]    gnt;
  logic [PW-1:0]         gnt_idx;
  logic [PW-1:0]         cand;
  logic                  gnt_any;
  logic                  grant_en;
  logic                  accept;
  logic                  keep;
  logic                  addr_ok;
  logic                  is_dup;
  logic [WIDTH_PKT-1:0]  sel_pkt;
  logic [WIDTH_ADDR-1:0] pkt_addr;
  logic [WIDTH_DATA-1:0] pkt_data;
  logic [WIDTH_DATA-1:0] res;
  logic                  spike;
  logic                  unused_pkt_bits;

  // Hold off grants while the final write is in flight so none lands in drain.
  assign grant_en = (state_q == S_COLLECT) &&
                    !(wr_pend_q && (cnt_q == LAST_CNT));

  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = PW'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!gnt_any && req_valid[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (grant_en && gnt_any) gnt[gnt_idx] = 1'b1;
  end

  assign req_ready = gnt;
  assign accept    = grant_en && gnt_any;

  always_comb begin
    sel_pkt = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt_idx == PW'(k)) sel_pkt = req_pkt[k*WIDTH_PKT +: WIDTH_PKT];
    end
  end

  assign pkt_addr = sel_pkt[WIDTH_DATA +: WIDTH_ADDR];
  assign pkt_data = sel_pkt[WIDTH_DATA-1:0];
  assign unused_pkt_bits = ^sel_pkt[WIDTH_PKT-1:WIDTH_DATA+WIDTH_ADDR];

  assign addr_ok = {1'b0, pkt_addr} < ENT_LIM;
  assign spike   = pkt_data >= THR;
  assign res     = spike ? (pkt_data - THR) : pkt_data;

`ifdef RESULT_DUP_CHECK_EN
  logic [NUM_ENT-1:0] wmap_q, wmap_d;

  always_comb begin
    wmap_d = wmap_q;
    if (state_q == S_IDLE && start) wmap_d = '0;
    else if (keep) wmap_d[pkt_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wmap_q <= '0;
    else        wmap_q <= wmap_d;
  end

  assign is_dup = addr_ok && wmap_q[pkt_addr];
`else
  assign is_dup = 1'b0;
`endif

  assign keep = accept && addr_ok && !is_dup;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_addr_d  = rd_addr_q;
    rr_ptr_d   = rr_ptr_q;
    wr_pend_d  = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    cap_d      = 1'b0;
    out_data_d = cap_q ? mem_rdata : out_data_q;
    err_d      = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (accept) begin
          rr_ptr_d = PW'((int'(gnt_idx) + 1) % NUM_REQ);
          if (!addr_ok || is_dup) err_d = 1'b1;
        end
        if (keep) begin
          wr_pend_d = 1'b1;
          wr_addr_d = pkt_addr;
          wr_data_d = {spike, res};
        end
        if (wr_pend_q) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            state_d   = S_DRAIN_RD;
            rd_addr_d = '0;
          end
        end
      end
      S_DRAIN_RD: begin
        cap_d   = 1'b1;
        state_d = S_DRAIN_OUT;
      end
      S_DRAIN_OUT: begin
        if (out_ready) begin
          if (rd_addr_q == LAST_ADDR) begin
            state_d = S_DONE;
          end else begin
            rd_addr_d = rd_addr_q + 1'b1;
            state_d   = S_DRAIN_RD;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      rd_addr_q  <= '0;
      rr_ptr_q   <= '0;
      wr_pend_q  <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      cap_q      <= 1'b0;
      out_data_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_addr_q  <= rd_addr_d;
      rr_ptr_q   <= rr_ptr_d;
      wr_pend_q  <= wr_pend_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      cap_q      <= cap_d;
      out_data_q <= out_data_d;
      err_q      <= err_d;
    end
  end

  assign mem_we    = wr_pend_q;
  assign mem_re    = (state_q == S_DRAIN_RD);
  assign mem_addr  = wr_pend_q ? wr_addr_q : (mem_re ? rd_addr_q : '0);
  assign mem_wdata = wr_pend_q ? wr_data_q : '0;
  // Read data is presented straight through on the first drain-out cycle.
  assign out_valid = (state_q == S_DRAIN_OUT);
  assign out_data  = cap_q ? mem_rdata : out_data_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign err       = err_q;

endmodule

// File: tb/tb_result_wb_ctrl.sv
// Scoreboard bench for result_wb_ctrl: queued write/drain expectations,
// monitors compare on mem_we, mem_re and out handshakes.
module tb_result_wb_ctrl;

  localparam int NENT = 441;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [3:0]   req_valid;
  logic [127:0] req_pkt;
  logic [3:0]   req_ready;
  logic         mem_we;
  logic [8:0]   mem_addr;
  logic [13:0]  mem_wdata;
  logic         mem_re;
  logic [13:0]  mem_rdata;
  logic         out_valid;
  logic [13:0]  out_data;
  logic         out_ready;
  logic         busy;
  logic         done;
  logic         err;

  always #5 clk = ~clk;

  result_wb_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .req_valid(req_valid), .req_pkt(req_pkt), .req_ready(req_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_re(mem_re), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .done(done), .err(err)
  );

  typedef struct { logic [31:0] pkt; logic [13:0] wd; } ent_t;
  typedef struct { logic [8:0] a; logic [13:0] d; int c; } wr_t;

  logic [13:0] mem [NENT];
  logic [13:0] exp_mem [NENT];
  bit          seen [NENT];
  ent_t        fq [4][$];
  wr_t         wq [$];
  logic [13:0] oq [$];
  int          grants [$];
  int          gcyc [$];
  int          pool [$];

  int   n_chk = 0, n_pass = 0;
  int   cyc = 0, exp_cnt = 0, rd_exp = 0, drn_cnt = 0, done_cnt = 0;
  bit   exp_err = 0, feed_en = 1, held = 0;
  logic [13:0] held_d;
  wr_t  wmon;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", nm, act, exp);
  endtask

  task automatic bad(input string nm);
    n_chk++;
    $display("FAIL %s", nm);
  endtask

  function automatic logic [13:0] thr(input logic [12:0] d);
    return (d >= 13'd64) ? {1'b1, d - 13'd64} : {1'b0, d};
  endfunction

  function automatic logic [31:0] mk(input int a, input int d);
    logic [31:0] p;
    p = '0;
    p[21:13] = a[8:0];
    p[12:0]  = d[12:0];
    return p;
  endfunction

  task automatic push(input int r, input int a, input int d,
                      input logic [13:0] wd);
    ent_t e;
    e.pkt = mk(a, d);
    e.wd  = wd;
    fq[r].push_back(e);
  endtask

  function automatic int fq_left();
    return fq[0].size() + fq[1].size() + fq[2].size() + fq[3].size();
  endfunction

  task automatic take(input int r);
    ent_t e;
    logic [8:0] a;
    e = fq[r].pop_front();
    a = e.pkt[21:13];
    grants.push_back(r);
    gcyc.push_back(cyc);
    if (a >= 9'd441) exp_err = 1;
`ifdef RESULT_DUP_CHECK_EN
    else if (seen[a]) exp_err = 1;
`endif
    else begin
      seen[a] = 1;
      exp_mem[a] = e.wd;
      wq.push_back('{a, e.wd, cyc + 1});
      exp_cnt++;
      if (exp_cnt == NENT)
        for (int k = 0; k < NENT; k++) oq.push_back(exp_mem[k]);
    end
  endtask

  always @(posedge clk) begin
    if (mem_we && mem_addr < 9'd441) mem[mem_addr] <= mem_wdata;
    mem_rdata <= (mem_re && mem_addr < 9'd441) ? mem[mem_addr] : 14'h0;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #2;
    for (int i = 0; i < 4; i++) begin
      if (feed_en && fq[i].size() > 0) begin
        req_valid[i] = 1'b1;
        req_pkt[i*32 +: 32] = fq[i][0].pkt;
      end else begin
        req_valid[i] = 1'b0;
        req_pkt[i*32 +: 32] = '0;
      end
    end
    #1;
    if ($countones(req_valid) > 1)
      chk("one_ready", 32'($countones(req_ready) <= 1), 1);
    for (int i = 0; i < 4; i++)
      if (req_valid[i] && req_ready[i]) take(i);
  end

  always @(negedge clk) begin
    if (mem_we) begin
      if (wq.size() == 0) begin
        bad("unexpected_write");
      end else begin
        wmon = wq.pop_front();
        chk("wr_addr", mem_addr, wmon.a);
        chk("wr_data", mem_wdata, wmon.d);
        chk("wr_cycle", cyc, wmon.c);
      end
    end
    if (mem_we && mem_re) bad("we_re_overlap");
    if (mem_re) begin
      chk("rd_addr", mem_addr, rd_exp);
      rd_exp++;
    end
    if (held) begin
      chk("stall_valid", out_valid, 1);
      chk("stall_data", out_data, held_d);
    end
    held = 0;
    if (out_valid) begin
      if (out_ready) begin
        if (oq.size() == 0) bad("unexpected_out");
        else chk("out_data", out_data, oq.pop_front());
        drn_cnt++;
      end else begin
        held   = 1;
        held_d = out_data;
      end
    end
    if (done) done_cnt++;
  end

  task automatic chk_zero(input string t);
    chk({t, "_req_ready"}, req_ready, 0);
    chk({t, "_mem_we"}, mem_we, 0);
    chk({t, "_mem_addr"}, mem_addr, 0);
    chk({t, "_mem_wdata"}, mem_wdata, 0);
    chk({t, "_mem_re"}, mem_re, 0);
    chk({t, "_out_valid"}, out_valid, 0);
    chk({t, "_out_data"}, out_data, 0);
    chk({t, "_busy"}, busy, 0);
    chk({t, "_done"}, done, 0);
    chk({t, "_err"}, err, 0);
  endtask

  task automatic do_start();
    @(posedge clk);
    #2 start = 1'b1;
    exp_cnt = 0;
    exp_err = 0;
    rd_exp = 0;
    drn_cnt = 0;
    done_cnt = 0;
    grants.delete();
    gcyc.delete();
    for (int k = 0; k < NENT; k++) seen[k] = 0;
    @(posedge clk);
    #2 start = 1'b0;
  endtask

  task automatic wait_fed(input int budget);
    int n;
    n = 0;
    while (fq_left() > 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (fq_left() > 0) bad("feed_timeout");
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (done_cnt == 0) bad("done_timeout");
  endtask

  task automatic shuffle_pool();
    for (int k = pool.size() - 1; k > 0; k--) begin
      int j, t;
      j = int'($urandom_range(0, k));
      t = pool[k];
      pool[k] = pool[j];
      pool[j] = t;
    end
  endtask

  task automatic push_pool();
    for (int k = 0; k < pool.size(); k++) begin
      int d;
      d = int'($urandom_range(0, 8191));
      push(k % 4, pool[k], d, thr(13'(d)));
    end
  endtask

  task automatic end_checks(input string t);
    repeat (2) @(posedge clk);
    #1;
    chk({t, "_done_once"}, done_cnt, 1);
    chk({t, "_busy_low"}, busy, 0);
    chk({t, "_drained"}, drn_cnt, NENT);
    chk({t, "_reads"}, rd_exp, NENT);
    chk({t, "_oq_empty"}, oq.size(), 0);
    chk({t, "_wq_empty"}, wq.size(), 0);
  endtask

  int g1 [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  int stall_base;
  int nwait;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    req_valid = '0;
    req_pkt = '0;
    out_ready = 1'b1;
    for (int k = 0; k < NENT; k++) begin
      mem[k] = '0;
      exp_mem[k] = '0;
    end
    repeat (2) @(posedge clk);
    #1 chk_zero("rst");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk_zero("idle");

    // Timestep 1: threshold vectors, round robin, full drain with stall
    do_start();
    @(posedge clk);
    #1;
    chk("ts1_busy", busy, 1);
    push(0, 10, 64, 14'd8192);
    push(0, 11, 63, 14'd63);
    push(1, 12, 8191, 14'd16319);
    push(1, 13, 0, 14'd0);
    push(2, 14, 100, 14'd8228);
    push(2, 15, 65, 14'd8193);
    push(3, 16, 127, 14'd8255);
    push(3, 17, 1, 14'd1);
    wait_fed(100);
    repeat (3) @(posedge clk);
    chk("rr4_count", grants.size(), 8);
    for (int k = 0; k < 8 && k < grants.size(); k++) begin
      chk("rr4_grant", grants[k], g1[k]);
      chk("rr4_back2back", gcyc[k] - gcyc[0], k);
    end
    grants.delete();
    gcyc.delete();
    @(posedge clk);
    #1;
    push(2, 20, 200, 14'd8328);
    push(2, 21, 64, 14'd8192);
    push(2, 22, 63, 14'd63);
    push(2, 23, 8191, 14'd16319);
    wait_fed(100);
    repeat (3) @(posedge clk);
    chk("rr1_count", grants.size(), 4);
    for (int k = 0; k < 4 && k < grants.size(); k++) begin
      chk("rr1_grant", grants[k], 2);
      chk("rr1_back2back", gcyc[k] - gcyc[0], k);
    end
    @(posedge clk);
    #1;
    pool.delete();
    for (int a = 0; a < NENT; a++)
      if (!((a >= 10 && a <= 17) || (a >= 20 && a <= 23))) pool.push_back(a);
    shuffle_pool();
    push_pool();
    nwait = 0;
    while (drn_cnt < 50 && nwait < 5000) begin
      @(posedge clk);
      nwait++;
    end
    if (drn_cnt < 50) bad("drain_start_timeout");
    #2 out_ready = 1'b0;
    stall_base = drn_cnt;
    repeat (10) @(posedge clk);
    #2;
    chk("stall_no_pop", drn_cnt, stall_base);
    out_ready = 1'b1;
    wait_done(3000);
    end_checks("ts1");
    chk("ts1_err", err, 0);

    // Timestep 2: out-of-range address, then duplicate address 5
    do_start();
    @(posedge clk);
    #1;
    push(0, 441, 5, 14'd0);
    for (int a = 0; a < 440; a++) begin
      int d;
      d = (a * 37) % 8192;
      push((a + 1) % 4, a, d, thr(13'(d)));
    end
    wait_fed(1000);
    repeat (5) @(posedge clk);
    #1;
    chk("bad_addr_err", err, 1);
    chk("bad_addr_model_err", err, exp_err);
    chk("bad_addr_no_drain", rd_exp, 0);
    chk("bad_addr_busy", busy, 1);
    chk("bad_addr_no_out", out_valid, 0);
    push(1, 5, 1000, thr(13'd1000));
    wait_fed(100);
`ifdef RESULT_DUP_CHECK_EN
    repeat (5) @(posedge clk);
    #1;
    chk("dup_err", err, 1);
    chk("dup_no_drain", rd_exp, 0);
    push(2, 440, 77, thr(13'd77));
`endif
    wait_done(3000);
    end_checks("ts2");
    chk("ts2_err", err, 1);

    // Timestep 3: reset after 200 entries, then a clean timestep
    do_start();
    @(posedge clk);
    #1;
    chk("start_clears_err", err, 0);
    pool.delete();
    for (int a = 0; a < NENT; a++) pool.push_back(a);
    shuffle_pool();
    push_pool();
    nwait = 0;
    do begin
      @(posedge clk);
      #1;
      nwait++;
    end while (exp_cnt < 200 && nwait < 2000);
    if (exp_cnt < 200) bad("collect_timeout");
    chk("pend_before_rst", mem_we, 1);
    rst_n = 1'b0;
    feed_en = 0;
    for (int i = 0; i < 4; i++) fq[i].delete();
    wq.delete();
    oq.delete();
    #1 chk_zero("midrst");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_we", mem_we, 0);
    chk("post_rst_busy", busy, 0);
    feed_en = 1;
    do_start();
    @(posedge clk);
    #1;
    pool.delete();
    for (int a = 0; a < NENT; a++) pool.push_back(a);
    shuffle_pool();
    push_pool();
    wait_done(3000);
    end_checks("ts3");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/result_wb_ctrl.md
RESULT_WB_CTRL -- requirements
Module: result_wb_ctrl

Interface
REQ-001 Parameters, SHALL be: NUM_REQ, 4, number of PE result requesters; WIDTH_PKT, 32, packet width; WIDTH_DATA, 13, residue width; DEPTH_R, 21, output map side (441 entries); WIDTH_ADDR, 9, entry address width; THRE, 64, spike threshold.
REQ-002 Ports SHALL be (name direction width meaning), with clock and reset first:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a timestep.
- req_valid  in  NUM_REQ  per-requester packet valid.
- req_pkt  in  NUM_REQ*WIDTH_PKT  packets; requester i at bits [i*32+:32]; addr = pkt[21:13], data = pkt[12:0].
- req_ready  out  NUM_REQ  per-requester accept.
- mem_we  out  1  residue/spike write strobe.
- mem_addr  out  WIDTH_ADDR  write/read address.
- mem_wdata  out  WIDTH_DATA+1  {spike, residue} write data.
- mem_re  out  1  read strobe.
- mem_rdata  in  WIDTH_DATA+1  read data, valid exactly 1 cycle after mem_re.
- out_valid  out  1  drained entry valid.
- out_data  out  WIDTH_DATA+1  drained {spike, residue}.
- out_ready  in  1  downstream accept.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at end of drain.
- err  out  1  sticky error flag.

Function
REQ-003 The FSM SHALL have states IDLE, COLLECT, DRAIN_RD, DRAIN_OUT, DONE.
REQ-004 In IDLE, start=1 SHALL clear the entry count and err, and enter COLLECT; start SHALL be ignored in all other states.
REQ-005 In COLLECT, a round-robin arbiter SHALL assert at most one req_ready bit per cycle, for the lowest valid index at or after the last-granted index+1 (mod NUM_REQ); req_ready SHALL be 0 outside COLLECT.
REQ-006 A packet SHALL be accepted when req_valid[i] and req_ready[i] are both 1; the pointer SHALL advance only on acceptance.
REQ-007 For each accepted packet, the block SHALL perform the threshold step: if data >= THRE then residue = data - THRE and spike = 1, else residue = data and spike = 0; the comparison SHALL be unsigned 13-bit.
REQ-008 The write SHALL be registered: mem_we=1 with the corresponding mem_addr and mem_wdata SHALL appear in the cycle after acceptance, with one write per accepted packet.
REQ-009 A packet with addr >= DEPTH_R**2 SHALL be accepted and dropped (no mem_we, not counted) and SHALL set err.
REQ-010 Each issued write SHALL increment the count; when count reaches 441, COLLECT SHALL exit to DRAIN_RD in the cycle after the 441st write, with rd_addr=0 and no further grants.
REQ-011 In DRAIN_RD, the block SHALL assert mem_re with mem_addr=rd_addr for one cycle, then go to DRAIN_OUT.
REQ-012 In DRAIN_OUT, the block SHALL capture mem_rdata into out_data and hold out_valid=1 with stable out_data until out_ready=1.
REQ-013 On the DRAIN_OUT handshake, if rd_addr=440 the FSM SHALL go to DONE, else it SHALL increment rd_addr and return to DRAIN_RD; drain throughput is therefore 1 entry per 2 cycles at best.
REQ-014 DONE SHALL assert done=1 for one cycle, then return to IDLE.
REQ-015 mem_we and mem_re SHALL never be asserted in the same cycle.

Reset
REQ-016 rst_n=0 SHALL asynchronously force: IDLE; count, rd_addr and RR pointer = 0; every output = 0.
REQ-017 Reset asserted mid-COLLECT or mid-DRAIN SHALL abort the operation, and no pending write SHALL issue after release.

Configuration
REQ-018 With RESULT_DUP_CHECK_EN defined, a 441-bit written bitmap (cleared on start and on reset) SHALL be kept; a packet to an already-written address SHALL be dropped, not counted, and SHALL set err.
REQ-019 Without RESULT_DUP_CHECK_EN, duplicates SHALL overwrite the entry and be counted, and no bitmap logic SHALL be built.

Verification
REQ-020 The bench SHALL cover these scenarios:
- Threshold: data=64 -> {1,0}; data=63 -> {0,63}; data=8191 -> {1,8127}; write seen 1 cycle after accept.
- Round robin: all 4 valid continuously -> grants 0,1,2,3,0...; only req 2 valid -> req 2 granted every cycle.
- Full timestep: 441 unique addrs in random order -> drain emits 441 entries at addresses 0..440 in order, done pulses once, busy falls.
- Backpressure: out_ready held low 10 cycles during drain -> out_valid and out_data stable, no entry lost or duplicated.
- Bad addr 441: err=1, no mem_we, count unchanged; with RESULT_DUP_CHECK_EN, a repeated addr 5 -> err=1 and the 441-count needs one more unique packet.
- Reset at entry 200 of COLLECT -> all outputs 0 immediately; a new start then completes normally.
